// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: signed/unsigned, one quotient
// bit per cycle, divide-by-zero detection, flush via cancel, stall toward CTRL.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             stallreq
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] part_rem;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  logic [WIDTH:0]   shifted, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             last_step;

  // The dividend shift register doubles as the quotient register: each step
  // consumes its MSB and shifts the new quotient bit into its LSB.
  always_comb begin
    shifted   = {part_rem, dvd_sh[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_mag};
    q_bit     = ~trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {dvd_sh[WIDTH-2:0], q_bit};
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !cancel) state_next = (divisor == '0) ? DONE : CALC;
      CALC: begin
        if (cancel)         state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign ready    = (state == DONE) && !cancel;
  assign stallreq = ((state == IDLE) && start && !cancel) || (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd_sh      <= '0;
      dvs_mag     <= '0;
      part_rem    <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            dvd_sh   <= (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_mag  <= (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
            q_neg    <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= signed_div && dividend[WIDTH-1];
            part_rem <= '0;
            cnt      <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          // A flush leaves the previously delivered results untouched.
          if (!cancel) begin
            part_rem <= rem_next;
            dvd_sh   <= quo_next;
            cnt      <= cnt + CNT_W'(1);
            if (last_step) begin
              quotient    <= q_neg ? -quo_next : quo_next;
              remainder   <= r_neg ? -rem_next : rem_next;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32): scoreboard of expected results
// consumed on each ready pulse, plus latency, stall-window, cancel and reset checks.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_div = 1'b0;
  logic             cancel = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, ready, div_by_zero, stallreq;
  logic [WIDTH-1:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } res_t;

  res_t sb[$];
  res_t expRes;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;
  int   startCycle = 0;
  int   stallCount = 0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .ready(ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard consumer: results are compared mid-cycle while ready is high.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious ready", 32'(ready), 32'd0);
      end else begin
        expRes = sb.pop_front();
        checkOutput("quotient", quotient, expRes.q);
        checkOutput("remainder", remainder, expRes.r);
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(expRes.dbz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stallreq) stallCount++;
  endtask

  task automatic applyStimulus(input logic sd, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er, input logic ed);
    res_t e;
    e.q = eq; e.r = er; e.dbz = ed;
    sb.push_back(e);
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    #1;
    checkOutput("stallreq on start", 32'(stallreq), 32'd1);
    stallCount = 1;
    @(posedge clk);
    #1;
    startCycle = cycle;
    start      = 1'b0;
    signed_div = $urandom_range(0, 1) == 1;
    dividend   = $urandom;
    divisor    = $urandom;
    #1;
    if (stallreq) stallCount++;
  endtask

  task automatic waitDone(input int expLat, input int expStall, input string tag);
    int budget = 0;
    while (!ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!ready) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " latency"}, 32'(cycle - startCycle + 1), 32'(expLat));
      checkOutput({tag, " stall cycles"}, 32'(stallCount), 32'(expStall));
      checkOutput({tag, " stallreq in DONE"}, 32'(stallreq), 32'd0);
      checkOutput({tag, " busy in DONE"}, 32'(busy), 32'd1);
    end
    tick();
    checkOutput({tag, " idle after DONE"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);
    checkOutput("reset stallreq", 32'(stallreq), 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    waitDone(33, 33, "100/7");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    waitDone(33, 33, "-7/2");
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    waitDone(33, 33, "7/-2");
    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    waitDone(33, 33, "divu big/2");
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    waitDone(33, 33, "-100/-7");

    applyStimulus(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    waitDone(1, 1, "5/0");
    applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    waitDone(33, 33, "9/3");

    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    waitDone(33, 33, "overflow");

    // Flush ten cycles into CALC: no result, outputs keep the overflow result.
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    void'(sb.pop_back());
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    #1;
    checkOutput("cancel busy", 32'(busy), 32'd0);
    checkOutput("cancel stallreq", 32'(stallreq), 32'd0);
    checkOutput("cancel quotient held", quotient, 32'h8000_0000);
    checkOutput("cancel remainder held", remainder, 32'd0);
    applyStimulus(1'b1, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    waitDone(33, 33, "after cancel");

    start = 1'b1;
    cancel = 1'b1;
    #1;
    checkOutput("start+cancel stallreq", 32'(stallreq), 32'd0);
    tick();
    start = 1'b0;
    cancel = 1'b0;
    #1;
    checkOutput("start+cancel busy", 32'(busy), 32'd0);

    applyStimulus(1'b0, 32'd77, 32'd7, 32'd0, 32'd0, 1'b0);
    void'(sb.pop_back());
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midop reset busy", 32'(busy), 32'd0);
    checkOutput("midop reset ready", 32'(ready), 32'd0);
    checkOutput("midop reset stallreq", 32'(stallreq), 32'd0);
    checkOutput("midop reset quotient", quotient, 32'd0);
    checkOutput("midop reset remainder", remainder, 32'd0);
    checkOutput("midop reset div_by_zero", 32'(div_by_zero), 32'd0);

    applyStimulus(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0);
    repeat (3) tick();
    signed_div = 1'b1;
    dividend   = 32'd999;
    divisor    = 32'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    waitDone(33, 33, "ignored start");

    repeat (3) tick();
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the EX stage of the five-stage MIPS pipeline. It accepts a signed or unsigned divide request, computes one quotient bit per cycle with a restoring algorithm, and asserts a stall request toward CTRL until the result is ready. It generalises the fixed 32-bit divider in three ways: configurable operand width, divide-by-zero detection, and a cancel input for pipeline flush.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and result width in bits, ≥ 4.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter.

**Ports** (clock and reset first)
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a divide; sampled only in IDLE.
- `signed_div`  in  1  1 selects signed (div), 0 selects unsigned (divu); sampled with `start`.
- `dividend`  in  WIDTH  numerator, sampled with `start`.
- `divisor`  in  WIDTH  denominator, sampled with `start`.
- `cancel`  in  1  flush: abort the operation in progress.
- `busy`  out  1  high while in CALC or DONE.
- `ready`  out  1  one-cycle pulse; results are valid.
- `quotient`  out  WIDTH  result, written to LO.
- `remainder`  out  WIDTH  result, written to HI.
- `div_by_zero`  out  1  the last completed operation had divisor 0.
- `stallreq`  out  1  stall request to CTRL.

## Operation

**States:** IDLE, CALC, DONE. Encoding is free.

**IDLE**
- Transitions require `start=1` and `cancel=0`.
- On `start` the unit latches:
  - the dividend and divisor magnitudes (two's-complement negated if `signed_div` and the MSB is 1);
  - `q_neg = signed_div & (dividend[MSB] ^ divisor[MSB])`;
  - `r_neg = signed_div & dividend[MSB]`.
- If `divisor == 0`, go to DONE and load:
  - `quotient = {WIDTH{1'b1}}`;
  - `remainder = dividend` (raw, unmodified);
  - `div_by_zero = 1`.
- Otherwise, go to CALC, clear the partial remainder (WIDTH+1 bits), and clear the counter.

**CALC**
- Each cycle, one restoring step:
  - shift the partial remainder left, bringing in the dividend MSB;
  - trial-subtract the divisor;
  - if the result is non-negative, keep it and set quotient bit 1; else restore and set bit 0.
- After exactly WIDTH steps, go to DONE:
  - `quotient` = the magnitude quotient, negated if `q_neg`;
  - `remainder` = the magnitude remainder, negated if `r_neg`;
  - `div_by_zero = 0`.

**DONE**
- `ready = 1` for this single cycle.
- Go to IDLE unconditionally.

**Output hold:** `quotient`, `remainder` and `div_by_zero` hold their values until the next completion or reset.

**Arithmetic rules**
- All arithmetic is modulo 2^WIDTH.
- Signed most-negative ÷ −1 is not trapped: it yields `quotient = 2^(WIDTH-1)` (most negative) and `remainder = 0`.

**stallreq**
- Combinational: `(state==IDLE & start & ~cancel) | state==CALC`.
- It is low in DONE, so EX can capture `quotient`/`remainder` while the pipeline advances.

**Cancel**
- `cancel=1` in CALC or DONE forces IDLE on the next edge.
- Result registers are not updated. If the cancel arrives in DONE, the current-cycle `ready` is suppressed (`ready` = DONE & ~cancel).
- `cancel` and `start` in the same IDLE cycle: cancel wins, and the request is dropped.

**Other boundary rules**
- `start` while busy is ignored. Inputs may change freely after the sampling cycle.
- `rst` in any state returns to IDLE; in-flight work is discarded.

## Timing

- **Reset values:** state IDLE; all outputs 0 (`busy`, `ready`, `quotient`, `remainder`, `div_by_zero`, `stallreq`).
- **Normal latency:** `start` sampled at edge *n* → CALC during cycles *n+1*…*n+WIDTH* → DONE and `ready` in cycle *n+WIDTH+1*. This is 33 cycles for WIDTH=32.
- **Divide-by-zero latency:** `ready` in cycle *n+1*.
- **Back-to-back:** the earliest next accepted `start` is the IDLE cycle after DONE, giving a throughput of WIDTH+2 cycles per operation.
- **Stall window:** `stallreq` is high from the `start` cycle through the last CALC cycle inclusive. A zero-divisor request stalls only for its `start` cycle.

## Test plan

All scenarios use WIDTH=32.

1. **Unsigned:** 100 ÷ 7 → `ready` exactly 33 cycles after `start`; `quotient` = 14, `remainder` = 2, `div_by_zero` = 0; `stallreq` high for 33 consecutive cycles.
2. **Signed mixed signs:** −7 ÷ 2 → `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF. Then 7 ÷ −2 → `quotient` = 0xFFFFFFFD, `remainder` = 1. Then unsigned 0xFFFFFFF9 ÷ 2 → `quotient` = 0x7FFFFFFC, `remainder` = 1.
3. **Divide by zero:** 5 ÷ 0 → `ready` 1 cycle after `start`; `quotient` = 0xFFFFFFFF, `remainder` = 5, `div_by_zero` = 1. A following 9 ÷ 3 clears `div_by_zero` and gives `quotient` = 3, `remainder` = 0.
4. **Signed overflow:** 0x80000000 ÷ 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0, no error flag.
5. **Cancel:** assert `cancel` 10 cycles into CALC → `busy`/`stallreq` low on the next cycle, no `ready` pulse, outputs unchanged. A `start` in the following cycle is accepted and completes correctly. Also cover `start` and `cancel` together in IDLE: no state change.
6. **Reset mid-operation and ignored start:** synchronous `rst` during CALC → all outputs 0 next cycle. A second `start` with different operands during CALC is ignored; the original result is delivered.
